// File: rtl/regfile_port_controller.sv
// Register-file write-port sequencer: post-reset init sweep, then wb/debug arbitration with a starvation slot.
// Latency: zero cycles, all outputs are combinational from state and inputs; the register file captures on the same edge.
// Backpressure: wb_stall holds the pipeline during init and forced debug slots; debug requests hold until dbg_gnt.
module regfile_port_controller #(
    parameter int          STARVE_LIMIT = 4,
    parameter logic [31:0] INIT_VALUE   = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_we,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        dbg_req,
    input  logic [4:0]  dbg_addr,
    input  logic [31:0] dbg_data,
    output logic        dbg_gnt,
    output logic        wb_stall,
    output logic        init_busy,
    output logic        rf_we,
    output logic [4:0]  rf_addr,
    output logic [31:0] rf_data
);

    localparam int WW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        INIT     = 2'd0,
        RUN      = 2'd1,
        DBG_SLOT = 2'd2
    } state_t;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    state_t        state, state_nxt;
    logic [4:0]    icnt, icnt_nxt;
    logic [WW-1:0] wcnt, wcnt_nxt;
    wr_t           sel;
    logic          sel_vld;
    logic          zero_guard;
    logic          rf_we_int;

    // State, init counter and starvation counter registers; reset restarts the init sweep.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= INIT;
            icnt  <= 5'd0;
            wcnt  <= '0;
        end else begin
            state <= state_nxt;
            icnt  <= icnt_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

    // Next-state and write-source selection; reset forces the quiet, stalled output set.
    always_comb begin
        state_nxt  = state;
        icnt_nxt   = icnt;
        wcnt_nxt   = wcnt;
        sel_vld    = 1'b0;
        sel        = '0;
        dbg_gnt    = 1'b0;
        wb_stall   = 1'b0;
        init_busy  = 1'b0;
        zero_guard = 1'b1;

        case (state)
            INIT: begin
                // Register 0 is written here too, so it starts at INIT_VALUE like the rest.
                sel_vld    = 1'b1;
                sel        = '{addr: icnt, data: INIT_VALUE};
                wb_stall   = 1'b1;
                init_busy  = 1'b1;
                zero_guard = 1'b0;
                icnt_nxt   = icnt + 5'd1;
                if (icnt == 5'd31) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (wb_we) begin
                    sel_vld = 1'b1;
                    sel     = '{addr: wb_addr, data: wb_data};
                    if (dbg_req) begin
                        // Last tolerated blocked cycle: steal the next cycle for debug.
                        if (wcnt == WW'(STARVE_LIMIT - 1)) begin
                            state_nxt = DBG_SLOT;
                            wcnt_nxt  = '0;
                        end else begin
                            wcnt_nxt = wcnt + 1'b1;
                        end
                    end else begin
                        wcnt_nxt = '0;
                    end
                end else if (dbg_req) begin
                    sel_vld  = 1'b1;
                    sel      = '{addr: dbg_addr, data: dbg_data};
                    dbg_gnt  = 1'b1;
                    wcnt_nxt = '0;
                end else begin
                    wcnt_nxt = '0;
                end
            end
            DBG_SLOT: begin
                // Pipeline holds; its write-back is re-presented next cycle.
                wb_stall  = 1'b1;
                state_nxt = RUN;
                if (dbg_req) begin
                    sel_vld = 1'b1;
                    sel     = '{addr: dbg_addr, data: dbg_data};
                    dbg_gnt = 1'b1;
                end
            end
            default: begin
                state_nxt = INIT;
                icnt_nxt  = 5'd0;
                wcnt_nxt  = '0;
            end
        endcase

        if (reset) begin
            sel_vld   = 1'b0;
            dbg_gnt   = 1'b0;
            wb_stall  = 1'b1;
            init_busy = 1'b1;
        end
    end

    // Register 0 stays zero after init: drop the write but keep any grant already issued.
    always_comb begin
        rf_we_int = sel_vld && !(zero_guard && (sel.addr == 5'd0));
        rf_we     = rf_we_int;
        rf_addr   = rf_we_int ? sel.addr : 5'd0;
        rf_data   = rf_we_int ? sel.data : 32'd0;
    end

endmodule

// File: tb/tb_regfile_port_controller.sv
module tb_regfile_port_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        dbg_req;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic        dbg_gnt;
    logic        wb_stall;
    logic        init_busy;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;

    int checks   = 0;
    int failures = 0;

    regfile_port_controller #(
        .STARVE_LIMIT(4),
        .INIT_VALUE  (32'h0)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wb_we    (wb_we),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .dbg_req  (dbg_req),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .dbg_gnt  (dbg_gnt),
        .wb_stall (wb_stall),
        .init_busy(init_busy),
        .rf_we    (rf_we),
        .rf_addr  (rf_addr),
        .rf_data  (rf_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb_we    = 1'b0;
        wb_addr  = 5'd0;
        wb_data  = 32'd0;
        dbg_req  = 1'b0;
        dbg_addr = 5'd0;
        dbg_data = 32'd0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        tick();

        // Reset cycle outputs
        chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
        chk("rst_dbg_gnt", {31'd0, dbg_gnt}, 32'd0);
        chk("rst_wb_stall", {31'd0, wb_stall}, 32'd1);
        chk("rst_init_busy", {31'd0, init_busy}, 32'd1);

        // Partial init: 10 cycles, then reset again
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("init1_we", {31'd0, rf_we}, 32'd1);
            chk("init1_addr", {27'd0, rf_addr}, i);
            tick();
        end
        reset = 1'b1;
        #1;
        chk("midrst_rf_we", {31'd0, rf_we}, 32'd0);
        chk("midrst_stall", {31'd0, wb_stall}, 32'd1);
        tick();
        reset = 1'b0;

        // Full init with requests presented; they must be ignored
        wb_we    = 1'b1;
        wb_addr  = 5'd17;
        wb_data  = 32'hCAFEF00D;
        dbg_req  = 1'b1;
        dbg_addr = 5'd22;
        dbg_data = 32'h0BADBEEF;
        for (int i = 0; i < 32; i++) begin
            #1;
            chk("init_we", {31'd0, rf_we}, 32'd1);
            chk("init_addr", {27'd0, rf_addr}, i);
            chk("init_data", rf_data, 32'h0);
            chk("init_busy", {31'd0, init_busy}, 32'd1);
            chk("init_stall", {31'd0, wb_stall}, 32'd1);
            chk("init_gnt", {31'd0, dbg_gnt}, 32'd0);
            if (i == 31) idle_inputs();
            tick();
        end

        // 33rd cycle: RUN, idle
        chk("run_init_busy", {31'd0, init_busy}, 32'd0);
        chk("run_stall", {31'd0, wb_stall}, 32'd0);
        chk("run_idle_we", {31'd0, rf_we}, 32'd0);
        chk("run_idle_addr", {27'd0, rf_addr}, 32'd0);

        // Write-back write
        wb_we   = 1'b1;
        wb_addr = 5'd5;
        wb_data = 32'hDEADBEEF;
        #1;
        chk("wb_we", {31'd0, rf_we}, 32'd1);
        chk("wb_addr", {27'd0, rf_addr}, 32'd5);
        chk("wb_data", rf_data, 32'hDEADBEEF);
        chk("wb_gnt", {31'd0, dbg_gnt}, 32'd0);
        tick();

        // Write-back to r0 suppressed
        wb_addr = 5'd0;
        wb_data = 32'h11111111;
        #1;
        chk("wb0_we", {31'd0, rf_we}, 32'd0);
        chk("wb0_data", rf_data, 32'd0);
        tick();

        // Debug write with write-back idle
        idle_inputs();
        dbg_req  = 1'b1;
        dbg_addr = 5'd7;
        dbg_data = 32'h12345678;
        #1;
        chk("dbg_gnt", {31'd0, dbg_gnt}, 32'd1);
        chk("dbg_we", {31'd0, rf_we}, 32'd1);
        chk("dbg_addr", {27'd0, rf_addr}, 32'd7);
        chk("dbg_data", rf_data, 32'h12345678);
        chk("dbg_stall", {31'd0, wb_stall}, 32'd0);
        tick();

        // Debug write to r0: granted but suppressed
        dbg_addr = 5'd0;
        #1;
        chk("dbg0_gnt", {31'd0, dbg_gnt}, 32'd1);
        chk("dbg0_we", {31'd0, rf_we}, 32'd0);
        tick();
        idle_inputs();
        tick();

        // Starvation: 4 blocked cycles then forced slot
        wb_we    = 1'b1;
        wb_addr  = 5'd3;
        dbg_req  = 1'b1;
        dbg_addr = 5'd9;
        dbg_data = 32'hAAAA5555;
        for (int k = 0; k < 4; k++) begin
            wb_data = 32'h100 + k;
            #1;
            chk("starve_wb_addr", {27'd0, rf_addr}, 32'd3);
            chk("starve_wb_data", rf_data, 32'h100 + k);
            chk("starve_gnt", {31'd0, dbg_gnt}, 32'd0);
            chk("starve_stall", {31'd0, wb_stall}, 32'd0);
            tick();
        end
        #1;
        chk("slot_stall", {31'd0, wb_stall}, 32'd1);
        chk("slot_gnt", {31'd0, dbg_gnt}, 32'd1);
        chk("slot_we", {31'd0, rf_we}, 32'd1);
        chk("slot_addr", {27'd0, rf_addr}, 32'd9);
        chk("slot_data", rf_data, 32'hAAAA5555);
        tick();
        dbg_req = 1'b0;
        #1;
        chk("resume_stall", {31'd0, wb_stall}, 32'd0);
        chk("resume_addr", {27'd0, rf_addr}, 32'd3);
        chk("resume_we", {31'd0, rf_we}, 32'd1);
        tick();

        // Request dropped before the slot: empty stall cycle
        dbg_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("drop_gnt", {31'd0, dbg_gnt}, 32'd0);
            tick();
        end
        dbg_req = 1'b0;
        #1;
        chk("drop_stall", {31'd0, wb_stall}, 32'd1);
        chk("drop_gnt_slot", {31'd0, dbg_gnt}, 32'd0);
        chk("drop_we", {31'd0, rf_we}, 32'd0);
        tick();
        #1;
        chk("drop_run_stall", {31'd0, wb_stall}, 32'd0);
        chk("drop_run_we", {31'd0, rf_we}, 32'd1);
        tick();

        // Reset while in the forced slot restarts init
        dbg_req = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        reset = 1'b1;
        #1;
        chk("slotrst_we", {31'd0, rf_we}, 32'd0);
        chk("slotrst_gnt", {31'd0, dbg_gnt}, 32'd0);
        tick();
        reset = 1'b0;
        idle_inputs();
        #1;
        chk("slotrst_busy", {31'd0, init_busy}, 32'd1);
        chk("slotrst_addr", {27'd0, rf_addr}, 32'd0);
        chk("slotrst_init_we", {31'd0, rf_we}, 32'd1);
        tick();
        #1;
        chk("slotrst_addr1", {27'd0, rf_addr}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_port_controller.md
# regfile_port_controller

Sequencer and write-port arbiter for the 32×32-bit register file in the instruction-decode stage. After reset it initialises every register through the single write port, then shares that port between the pipeline write-back stage and a debug/loader requester. Write-back has priority; a starvation limit guarantees the debug requester a slot by stalling the pipeline for one cycle. Register 0 is kept hardwired to zero by suppressing all post-init writes to address 0.

## Interface
- STARVE_LIMIT, 4, cycles a pending debug request may be blocked before a forced slot (≥1)
- INIT_VALUE, 32'h0, value written to every register during initialisation

- clk  in  1  clock
- reset  in  1  synchronous, active-high
- wb_we  in  1  write-back stage write request
- wb_addr  in  5  write-back destination register
- wb_data  in  32  write-back data
- dbg_req  in  1  debug write request; held with addr/data until granted
- dbg_addr  in  5  debug destination register
- dbg_data  in  32  debug write data
- dbg_gnt  out  1  one-cycle grant; debug write is presented to the register file this cycle
- wb_stall  out  1  pipeline must hold; write-back request is not accepted this cycle
- init_busy  out  1  initialisation in progress
- rf_we  out  1  register file write enable
- rf_addr  out  5  register file write address
- rf_data  out  32  register file write data

## Operation
- States: INIT, RUN, DBG_SLOT. Internal: 5-bit init counter `icnt`, wait counter `wcnt` (ceil(log2(STARVE_LIMIT+1)) bits).
- Reset cycle: state←INIT, icnt←0, wcnt←0. During reset: rf_we=0, dbg_gnt=0, wb_stall=1, init_busy=1.
- INIT: rf_we=1, rf_addr=icnt, rf_data=INIT_VALUE (address 0 included); wb_stall=1, init_busy=1, dbg_gnt=0; wb_we and dbg_req ignored. icnt increments; at icnt=31 → RUN. Exactly 32 cycles.
- RUN (init_busy=0, wb_stall=0):
  - wb_we=1: rf_* driven from wb_*; dbg_gnt=0. If dbg_req=1, wcnt increments; when the blocked cycle has wcnt=STARVE_LIMIT−1 → DBG_SLOT, wcnt←0.
  - wb_we=0, dbg_req=1: rf_* from dbg_*; dbg_gnt=1; wcnt←0.
  - neither: rf_we=0.
  - dbg_req=0: wcnt←0.
- DBG_SLOT: wb_stall=1; wb_we ignored (stage re-presents next cycle). If dbg_req=1: rf_* from dbg_*, dbg_gnt=1. If dbg_req=0: no write, dbg_gnt=0. Always → RUN.
- Zero guard: outside INIT, any selected write with address 0 drives rf_we=0; the grant (dbg_gnt) is still given.
- rf_addr/rf_data are don't-care when rf_we=0; drive 0.

## Timing
- rf_*, dbg_gnt, wb_stall, init_busy are combinational from state and inputs; the register file captures on the same rising edge.
- First RUN cycle is the 33rd cycle after reset deasserts; init_busy falls at that cycle.
- Debug latency: 0 cycles when write-back is idle; worst case STARVE_LIMIT blocked cycles plus 1 slot cycle under continuous write-back.
- Requester keeps dbg_req/addr/data stable until the dbg_gnt cycle; it may drop or present a new request the following cycle.
- Reset asserted in any state, including mid-INIT or DBG_SLOT, restarts INIT at icnt=0 on the next cycle; no partial write completes in the reset cycle.
- Stall has a width of exactly one cycle per forced slot; forced slots are separated by at least STARVE_LIMIT cycles.

## Test plan
- Reset, then idle 32 cycles -> rf_we=1 with rf_addr 0..31 in order, rf_data=0; init_busy=1 and wb_stall=1 throughout; init_busy=0 at cycle 33.
- Assert reset at init cycle 10, release -> writes restart at rf_addr=0, 32 more init cycles.
- RUN, wb_we=1 addr 5 data 32'hDEADBEEF -> rf_we=1, rf_addr=5, same cycle; wb_we=1 addr 0 -> rf_we=0.
- RUN, wb idle, dbg_req addr 7 data 32'h12345678 -> dbg_gnt=1 and rf write to 7 same cycle; dbg addr 0 -> dbg_gnt=1, rf_we=0.
- Continuous wb_we=1, dbg_req held, STARVE_LIMIT=4 -> 4 cycles of write-back writes, 5th cycle wb_stall=1, dbg_gnt=1, debug write; write-back resumes next cycle.
- dbg_req dropped after 4 blocked cycles -> DBG_SLOT cycle has wb_stall=1, dbg_gnt=0, rf_we=0, then RUN.
